// File: rtl/sitcp_tx_mux.sv
// sitcp_tx_mux: per-channel word FIFOs, round-robin framed bursts, MSB-first onto SiTCP's 8-bit TX port.
// Build option: define SITCP_TX_TRAILER_EN to append an XOR-of-payload trailer byte to every frame.
module sitcp_tx_mux #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 512,
    parameter int PROG_FULL = 496,
    parameter int MAX_BURST = 64
) (
    input  logic                   CLK_200M,
    input  logic                   SYS_RSTn,
    input  logic                   TCP_OPEN_ACK,
    input  logic                   SOFT_RESET,
    input  logic [N_CH*DATA_W-1:0] CH_DATA_IN,
    input  logic [N_CH-1:0]        CH_EN_IN,
    output logic [N_CH-1:0]        CH_FULL,
    output logic [N_CH-1:0]        CH_OVF,
    input  logic                   TCP_TX_FULL,
    output logic                   TCP_TX_WR,
    output logic [7:0]             TCP_TX_DATA
);
    localparam int BPW   = DATA_W / 8;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BI_W  = (BPW > 1) ? $clog2(BPW) : 1;

    // IDLE scan+grant | HDR 0xA0|g | LEN blen-1 | PAY payload bytes | TRL xor trailer
`ifdef SITCP_TX_TRAILER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_PAY, S_TRL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_LEN, S_PAY} state_t;
`endif

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [8:0]        blen_q, blen_d;
    logic [8:0]        wcnt_q, wcnt_d;
    logic [BI_W-1:0]   bidx_q, bidx_d;
    logic              wr_q, wr_d;
    logic [7:0]        data_q, data_d;
`ifdef SITCP_TX_TRAILER_EN
    logic [7:0]        chk_q, chk_d;
`endif
    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [CNT_W-1:0]  cnt_d  [N_CH];
    logic [PTR_W-1:0]  wptr_q [N_CH];
    logic [PTR_W-1:0]  wptr_d [N_CH];
    logic [PTR_W-1:0]  rptr_q [N_CH];
    logic [PTR_W-1:0]  rptr_d [N_CH];
    logic [N_CH-1:0]   full_q, full_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q  [N_CH][DEPTH];

    logic              flush;
    logic              pop;
    logic              pop_c;
    logic [N_CH-1:0]   wr_acc;
    logic              found;
    logic [CH_W-1:0]   scan_g;
    int                idx;
    logic [DATA_W-1:0] cur_word;
    logic [7:0]        cur_byte;

    assign flush = ~TCP_OPEN_ACK | SOFT_RESET;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        blen_d   = blen_q;
        wcnt_d   = wcnt_q;
        bidx_d   = bidx_q;
        wr_d     = 1'b0;
        data_d   = data_q;
`ifdef SITCP_TX_TRAILER_EN
        chk_d    = chk_q;
`endif
        pop      = 1'b0;
        found    = 1'b0;
        scan_g   = '0;
        idx      = 0;
        cur_word = mem_q[grant_q][rptr_q[grant_q]];
        cur_byte = cur_word[(BPW - 1 - int'(bidx_q)) * 8 +: 8];

        // Search order starts just after the last served channel.
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && cnt_q[idx] != '0) begin
                found  = 1'b1;
                scan_g = CH_W'(idx);
            end
        end

        if (!TCP_TX_FULL) begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_d = scan_g;
                        last_d  = scan_g;
                        blen_d  = (int'(cnt_q[scan_g]) < MAX_BURST) ? 9'(cnt_q[scan_g]) : 9'(MAX_BURST);
                        wcnt_d  = '0;
                        bidx_d  = '0;
`ifdef SITCP_TX_TRAILER_EN
                        chk_d   = '0;
`endif
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    wr_d    = 1'b1;
                    data_d  = 8'hA0 | {4'h0, 4'(grant_q)};
                    state_d = S_LEN;
                end
                S_LEN: begin
                    wr_d    = 1'b1;
                    data_d  = 8'(blen_q - 9'd1);
                    state_d = S_PAY;
                end
                S_PAY: begin
                    wr_d   = 1'b1;
                    data_d = cur_byte;
`ifdef SITCP_TX_TRAILER_EN
                    chk_d  = chk_q ^ cur_byte;
`endif
                    if (bidx_q == BI_W'(BPW - 1)) begin
                        pop    = 1'b1;
                        bidx_d = '0;
                        wcnt_d = wcnt_q + 9'd1;
                        if ((wcnt_q + 9'd1) == blen_q) begin
`ifdef SITCP_TX_TRAILER_EN
                            state_d = S_TRL;
`else
                            state_d = S_IDLE;
`endif
                        end
                    end else begin
                        bidx_d = bidx_q + BI_W'(1);
                    end
                end
`ifdef SITCP_TX_TRAILER_EN
                S_TRL: begin
                    wr_d    = 1'b1;
                    data_d  = chk_q;
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (flush) begin
            state_d = S_IDLE;
            last_d  = CH_W'(N_CH - 1);
            wr_d    = 1'b0;
            pop     = 1'b0;
        end

        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        wr_acc = '0;
        pop_c  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            pop_c     = pop && (grant_q == CH_W'(c));
            // A write into a full FIFO is only safe when a pop frees a slot on the same edge.
            wr_acc[c] = CH_EN_IN[c] && !flush && ((cnt_q[c] != CNT_W'(DEPTH)) || pop_c);
            if (flush) begin
                cnt_d[c]  = '0;
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                ovf_d[c]  = 1'b0;
            end else begin
                if (wr_acc[c]) wptr_d[c] = wptr_q[c] + PTR_W'(1);
                if (pop_c)     rptr_d[c] = rptr_q[c] + PTR_W'(1);
                if (wr_acc[c] && !pop_c)      cnt_d[c] = cnt_q[c] + CNT_W'(1);
                else if (!wr_acc[c] && pop_c) cnt_d[c] = cnt_q[c] - CNT_W'(1);
                if (CH_EN_IN[c] && !wr_acc[c]) ovf_d[c] = 1'b1;
            end
            full_d[c] = (cnt_d[c] >= CNT_W'(PROG_FULL));
        end
    end

    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= CH_W'(N_CH - 1);
            blen_q  <= '0;
            wcnt_q  <= '0;
            bidx_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
`ifdef SITCP_TX_TRAILER_EN
            chk_q   <= '0;
`endif
            full_q  <= '0;
            ovf_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]  <= '0;
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            blen_q  <= blen_d;
            wcnt_q  <= wcnt_d;
            bidx_q  <= bidx_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
`ifdef SITCP_TX_TRAILER_EN
            chk_q   <= chk_d;
`endif
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge CLK_200M) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wr_acc[c]) mem_q[c][wptr_q[c]] <= CH_DATA_IN[c*DATA_W +: DATA_W];
        end
    end

    assign TCP_TX_WR   = wr_q;
    assign TCP_TX_DATA = data_q;
    assign CH_FULL     = full_q;
    assign CH_OVF      = ovf_q;

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Testbench for sitcp_tx_mux: directed scenarios plus random traffic against a queue-based frame model.
module tb_sitcp_tx_mux;
    localparam int N_CH      = 4;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 512;
    localparam int PROG_FULL = 496;
    localparam int MAX_BURST = 2;
    localparam int BPW       = DATA_W / 8;
`ifdef SITCP_TX_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic                   clk_200m;
    logic                   sys_rst_n;
    logic                   tcp_open_ack;
    logic                   soft_reset;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_en;
    logic [N_CH-1:0]        ch_full;
    logic [N_CH-1:0]        ch_ovf;
    logic                   tcp_tx_full;
    logic                   tcp_tx_wr;
    logic [7:0]             tcp_tx_data;

    sitcp_tx_mux #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROG_FULL(PROG_FULL), .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK_200M    (clk_200m),
        .SYS_RSTn    (sys_rst_n),
        .TCP_OPEN_ACK(tcp_open_ack),
        .SOFT_RESET  (soft_reset),
        .CH_DATA_IN  (ch_data),
        .CH_EN_IN    (ch_en),
        .CH_FULL     (ch_full),
        .CH_OVF      (ch_ovf),
        .TCP_TX_FULL (tcp_tx_full),
        .TCP_TX_WR   (tcp_tx_wr),
        .TCP_TX_DATA (tcp_tx_data)
    );

    initial clk_200m = 1'b0;
    always #5 clk_200m = ~clk_200m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: channel queues plus a queue of bytes the current frame still owes.
    typedef struct {
        logic [7:0] b;
        bit         pop;
        int         ch;
    } ebyte_t;

    logic [DATA_W-1:0] mq [N_CH][$];
    ebyte_t            pend[$];
    int                m_last;
    bit                m_wr;
    logic [7:0]        m_data;
    logic [N_CH-1:0]   m_full;
    logic [N_CH-1:0]   m_ovf;
    logic [7:0]        got[$];

    task automatic m_reset();
        for (int c = 0; c < N_CH; c++) mq[c].delete();
        pend.delete();
        m_last = N_CH - 1;
        m_wr   = 1'b0;
        m_data = 8'h00;
        m_full = '0;
        m_ovf  = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit p, input int c);
        ebyte_t e;
        e.b = b;
        e.pop = p;
        e.ch = c;
        pend.push_back(e);
    endtask

    task automatic build_frame(input int c);
        int         n;
        logic [7:0] x;
        logic [7:0] b;
        n = (mq[c].size() < MAX_BURST) ? mq[c].size() : MAX_BURST;
        x = 8'h00;
        push_byte(8'hA0 | 8'(c), 1'b0, c);
        push_byte(8'(n - 1), 1'b0, c);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < BPW; k++) begin
                b = 8'(mq[c][w] >> (8 * (BPW - 1 - k)));
                x = x ^ b;
                push_byte(b, (k == BPW - 1), c);
            end
        end
        if (TRL == 1) push_byte(x, 1'b0, c);
        m_last = c;
    endtask

    task automatic m_step();
        ebyte_t e;
        if (!tcp_open_ack || soft_reset) begin
            m_reset();
            return;
        end
        m_wr = 1'b0;
        if (!tcp_tx_full) begin
            if (pend.size() > 0) begin
                e = pend.pop_front();
                m_wr = 1'b1;
                m_data = e.b;
                if (e.pop) void'(mq[e.ch].pop_front());
            end else begin
                for (int i = 1; i <= N_CH; i++) begin
                    if (mq[(m_last + i) % N_CH].size() > 0) begin
                        build_frame((m_last + i) % N_CH);
                        break;
                    end
                end
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (ch_en[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(ch_data[c*DATA_W +: DATA_W]);
                else m_ovf[c] = 1'b1;
            end
            m_full[c] = (mq[c].size() >= PROG_FULL);
        end
    endtask

    task automatic tick();
        @(posedge clk_200m);
        m_step();
        @(negedge clk_200m);
        chk("tx_wr", tcp_tx_wr, m_wr);
        if (m_wr) chk("tx_data", tcp_tx_data, m_data);
        chk("ch_full", ch_full, m_full);
        chk("ch_ovf", ch_ovf, m_ovf);
        if (tcp_tx_wr === 1'b1) got.push_back(tcp_tx_data);
    endtask

    logic [7:0]        exp_q[$];
    logic [DATA_W-1:0] bp_words[4];
    int                f1, f2;
    int                rate;

    initial begin
        sys_rst_n    = 1'b0;
        tcp_open_ack = 1'b1;
        soft_reset   = 1'b0;
        tcp_tx_full  = 1'b0;
        ch_en        = '0;
        ch_data      = '0;
        m_reset();
        repeat (3) @(negedge clk_200m);
        chk("rst_wr", tcp_tx_wr, 0);
        chk("rst_data", tcp_tx_data, 0);
        chk("rst_full", ch_full, 0);
        chk("rst_ovf", ch_ovf, 0);
        sys_rst_n = 1'b1;
        tick();

        // Single word on ch2, header two edges after the write edge.
        got.delete();
        ch_data[2*DATA_W +: DATA_W] = 32'h11223344;
        ch_en = 4'b0100;
        tick();
        ch_en = '0;
        tick();
        chk("hdr_lat_k1", tcp_tx_wr, 0);
        tick();
        chk("hdr_lat_k2_wr", tcp_tx_wr, 1);
        chk("hdr_lat_k2_byte", tcp_tx_data, 8'hA2);
        repeat (8) tick();
        exp_q.delete();
        exp_q.push_back(8'hA2); exp_q.push_back(8'h00); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        if (TRL == 1) exp_q.push_back(8'h44);
        chk("single_len", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk("single_byte", got[i], exp_q[i]);

        // Round-robin ch0/ch3 with 3 words each, loaded while the link is stalled.
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        got.delete();
        tcp_tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_data = {$urandom, $urandom, $urandom, $urandom};
            ch_en = 4'b1001;
            tick();
        end
        ch_en = '0;
        tcp_tx_full = 1'b0;
        repeat (45) tick();
        f2 = 2 + 2 * BPW + TRL;
        f1 = 2 + BPW + TRL;
        chk("rr_total", got.size(), 2 * f2 + 2 * f1);
        chk("rr_h0", got[0], 8'hA0);        chk("rr_l0", got[1], 8'h01);
        chk("rr_h1", got[f2], 8'hA3);       chk("rr_l1", got[f2+1], 8'h01);
        chk("rr_h2", got[2*f2], 8'hA0);     chk("rr_l2", got[2*f2+1], 8'h00);
        chk("rr_h3", got[2*f2+f1], 8'hA3);  chk("rr_l3", got[2*f2+f1+1], 8'h00);

        // Back-pressure for 5 cycles in the middle of a payload.
        got.delete();
        bp_words[0] = 32'hA1B2C3D4; bp_words[1] = 32'h55667788;
        bp_words[2] = 32'h0F1E2D3C; bp_words[3] = 32'hCAFEF00D;
        tcp_tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_data[1*DATA_W +: DATA_W] = bp_words[i];
            ch_en = 4'b0010;
            tick();
        end
        ch_en = '0;
        tcp_tx_full = 1'b0;
        repeat (5) tick();
        tcp_tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_wr_low", tcp_tx_wr, 0);
        end
        tcp_tx_full = 1'b0;
        repeat (30) tick();
        chk("bp_total", got.size(), 2 * f2);
        for (int i = 0; i < 2 * BPW; i++)
            chk("bp_payload", got[2+i], 8'(bp_words[i/BPW] >> (8 * (BPW - 1 - i % BPW))));

        // Overflow: 513 writes into ch1 while SiTCP is almost-full.
        got.delete();
        tcp_tx_full = 1'b1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            ch_data[1*DATA_W +: DATA_W] = $urandom;
            ch_en = 4'b0010;
            tick();
            if (i == PROG_FULL - 1) chk("full_before", ch_full[1], 0);
            if (i == PROG_FULL)     chk("full_at", ch_full[1], 1);
            if (i == DEPTH)         chk("ovf_before", ch_ovf[1], 0);
            if (i == DEPTH + 1)     chk("ovf_at", ch_ovf[1], 1);
        end
        ch_en = '0;
        tcp_tx_full = 1'b0;
        repeat ((DEPTH / MAX_BURST) * (f2 + 1) + 20) tick();
        chk("drain_bytes", got.size(), DEPTH * BPW + (DEPTH / MAX_BURST) * (2 + TRL));

        // Flush during PAY.
        for (int i = 0; i < 2; i++) begin
            ch_data[2*DATA_W +: DATA_W] = $urandom;
            ch_en = 4'b0100;
            tick();
        end
        ch_en = '0;
        repeat (3) tick();
        chk("pre_flush_wr", tcp_tx_wr, 1);
        tcp_open_ack = 1'b0;
        tick();
        chk("flush_wr", tcp_tx_wr, 0);
        chk("flush_ovf", ch_ovf, 0);
        chk("flush_full", ch_full, 0);
        tcp_open_ack = 1'b1;
        got.delete();
        repeat (5) tick();
        chk("flush_empty", got.size(), 0);
        ch_data[0 +: DATA_W] = 32'h01020304;
        ch_en = 4'b0001;
        tick();
        ch_en = '0;
        repeat (10) tick();
        chk("reopen_hdr", got[0], 8'hA0);
        chk("reopen_len", got.size(), f1);

        // Asynchronous reset in the middle of a frame, with CH_FULL/CH_OVF set.
        tcp_tx_full = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            ch_data[3*DATA_W +: DATA_W] = $urandom;
            ch_en = 4'b1000;
            tick();
        end
        ch_en = '0;
        tcp_tx_full = 1'b0;
        repeat (4) tick();
        chk("pre_rst_full", ch_full[3], 1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_wr", tcp_tx_wr, 0);
        chk("arst_data", tcp_tx_data, 0);
        chk("arst_full", ch_full, 0);
        chk("arst_ovf", ch_ovf, 0);
        @(negedge clk_200m);
        m_reset();
        sys_rst_n = 1'b1;
        tick();

        // Random traffic at three load levels.
        for (int p = 0; p < 3; p++) begin
            rate = (p == 0) ? 4 : ((p == 1) ? 10 : 35);
            for (int t = 0; t < 1000; t++) begin
                ch_data = {$urandom, $urandom, $urandom, $urandom};
                for (int c = 0; c < N_CH; c++) ch_en[c] = ($urandom_range(0, 99) < rate);
                tcp_tx_full  = ($urandom_range(0, 99) < 20);
                soft_reset   = ($urandom_range(0, 999) < 4);
                tcp_open_ack = ($urandom_range(0, 999) >= 3);
                tick();
            end
        end
        ch_en = '0;
        soft_reset = 1'b0;
        tcp_open_ack = 1'b1;
        tcp_tx_full = 1'b0;
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
